// File: rtl/lcd_init_mux.sv
`default_nettype none
// ============================================================================
// Module   : lcd_init_mux
// Purpose  : HD44780 power-up/init sequencer, character pass-through and
//            automatic line-wrap cursor commands for an 8-bit LCD bus.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_init_mux #(
    parameter int POWERUP_CYC = 20,
    parameter int WAIT_CYC    = 2,
    parameter int LINE_LEN    = 16
) (
    input  logic       clk_1024,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_e,
    input  logic       in_rw,
    input  logic       in_rs,
    output logic [7:0] lcd_data,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       busy,
    output logic       overrun,
    output logic [4:0] char_pos
);

    localparam int CNT_MAX = (POWERUP_CYC > WAIT_CYC) ? POWERUP_CYC : WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_pwr_last  = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(WAIT_CYC - 1);
    localparam logic [5:0]       c_line1_end = 6'(LINE_LEN);
    localparam logic [5:0]       c_line2_end = 6'(2 * LINE_LEN);
    localparam logic [7:0]       c_cmd_line1 = 8'h80;
    localparam logic [7:0]       c_cmd_line2 = 8'hC0;

    typedef enum logic [1:0] {
        S_PWRUP = 2'd0,
        S_CMD   = 2'd1,
        S_WAIT  = 2'd2,
        S_PASS  = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [1:0]         phase_q,    phase_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [1:0]         idx_q,      idx_d;
    logic               init_q,     init_d;
    logic [7:0]         cmd_q,      cmd_d;
    logic [7:0]         lcd_data_q, lcd_data_d;
    logic               lcd_e_q,    lcd_e_d;
    logic               lcd_rw_q,   lcd_rw_d;
    logic               lcd_rs_q,   lcd_rs_d;
    logic               busy_q,     busy_d;
    logic               overrun_q,  overrun_d;
    logic [4:0]         char_pos_q, char_pos_d;
    logic               in_e_d_q,   in_e_d_d;

    logic [5:0]         pos_inc;
    logic               start_cmd;
    logic [7:0]         next_cmd;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    always_ff @(posedge clk_1024) begin
        if (reset) begin
            state_q    <= S_PWRUP;
            phase_q    <= 2'd0;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            init_q     <= 1'b1;
            cmd_q      <= 8'h00;
            lcd_data_q <= 8'h00;
            lcd_e_q    <= 1'b0;
            lcd_rw_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            busy_q     <= 1'b1;
            overrun_q  <= 1'b0;
            char_pos_q <= 5'd0;
            in_e_d_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            init_q     <= init_d;
            cmd_q      <= cmd_d;
            lcd_data_q <= lcd_data_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rw_q   <= lcd_rw_d;
            lcd_rs_q   <= lcd_rs_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            char_pos_q <= char_pos_d;
            in_e_d_q   <= in_e_d_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        init_d     = init_q;
        cmd_d      = cmd_q;
        lcd_data_d = lcd_data_q;
        lcd_e_d    = lcd_e_q;
        lcd_rw_d   = lcd_rw_q;
        lcd_rs_d   = lcd_rs_q;
        busy_d     = busy_q;
        char_pos_d = char_pos_q;
        in_e_d_d   = in_e;
        overrun_d  = overrun_q | ((state_q != S_PASS) & in_e & ~in_e_d_q);
        pos_inc    = {1'b0, char_pos_q} + 6'd1;
        start_cmd  = 1'b0;
        next_cmd   = cmd_q;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == c_pwr_last) begin
                    start_cmd = 1'b1;
                    next_cmd  = init_cmd(2'd0);
                    idx_d     = 2'd0;
                    init_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CMD: begin
                phase_d = phase_q + 2'd1;
                lcd_e_d = (phase_q == 2'd0) || (phase_q == 2'd1);
                if (phase_q == 2'd3) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == c_wait_last) begin
                    if (init_q && (idx_q != 2'd3)) begin
                        start_cmd = 1'b1;
                        idx_d     = idx_q + 2'd1;
                        next_cmd  = init_cmd(idx_q + 2'd1);
                    end else begin
                        state_d = S_PASS;
                        init_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                lcd_data_d = in_data;
                lcd_e_d    = in_e;
                lcd_rw_d   = in_rw;
                lcd_rs_d   = in_rs;
                busy_d     = 1'b0;
                // A data write completes on the falling edge of E as seen at the pins
                if (lcd_e_q && !in_e && in_rs && !in_rw) begin
                    if (pos_inc == c_line1_end) begin
                        char_pos_d = pos_inc[4:0];
                        start_cmd  = 1'b1;
                        next_cmd   = c_cmd_line2;
                    end else if (pos_inc == c_line2_end) begin
                        char_pos_d = 5'd0;
                        start_cmd  = 1'b1;
                        next_cmd   = c_cmd_line1;
                    end else begin
                        char_pos_d = pos_inc[4:0];
                    end
                end
            end
        endcase

        if (start_cmd) begin
            state_d    = S_CMD;
            phase_d    = 2'd0;
            cmd_d      = next_cmd;
            lcd_data_d = next_cmd;
            lcd_e_d    = 1'b0;
            lcd_rw_d   = 1'b0;
            lcd_rs_d   = 1'b0;
            busy_d     = 1'b1;
        end
    end

    assign lcd_data = lcd_data_q;
    assign lcd_e    = lcd_e_q;
    assign lcd_rw   = lcd_rw_q;
    assign lcd_rs   = lcd_rs_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign char_pos = char_pos_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_init_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_init_mux
// Purpose  : Directed self-checking bench for lcd_init_mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_init_mux;

    logic       clk_1024 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_e     = 1'b0;
    logic       in_rw    = 1'b0;
    logic       in_rs    = 1'b0;
    logic [7:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rw;
    logic       lcd_rs;
    logic       busy;
    logic       overrun;
    logic [4:0] char_pos;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_init_mux dut (
        .clk_1024 (clk_1024),
        .reset    (reset),
        .in_data  (in_data),
        .in_e     (in_e),
        .in_rw    (in_rw),
        .in_rs    (in_rs),
        .lcd_data (lcd_data),
        .lcd_e    (lcd_e),
        .lcd_rw   (lcd_rw),
        .lcd_rs   (lcd_rs),
        .busy     (busy),
        .overrun  (overrun),
        .char_pos (char_pos)
    );

    always #5 clk_1024 = ~clk_1024;

    task automatic tick();
        @(posedge clk_1024);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_data = 8'h00;
        in_e    = 1'b0;
        in_rw   = 1'b0;
        in_rs   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Edge n counts from the reset edge; commands start at edge 20, six edges each.
    task automatic run_init(input bit poke, input int last);
        int k;
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_pos", 32'(char_pos), 32'd0);
        for (int n = 1; n <= last; n++) begin
            if (poke && n == 25) begin
                in_e    = 1'b1;
                in_data = 8'hAA;
                in_rs   = 1'b1;
            end
            if (poke && n == 31) in_e = 1'b0;
            tick();
            k = n - 20;
            chk($sformatf("init_e@%0d", n), 32'(lcd_e),
                32'((n >= 20) && (n < 44) && ((k % 6 == 1) || (k % 6 == 2))));
            chk($sformatf("init_rs@%0d", n), 32'(lcd_rs), 32'd0);
            chk($sformatf("init_rw@%0d", n), 32'(lcd_rw), 32'd0);
            chk($sformatf("init_busy@%0d", n), 32'(busy), 32'(n < 44));
            chk($sformatf("init_ovr@%0d", n), 32'(overrun), 32'(poke && n >= 25));
            if (n < 20)
                chk($sformatf("init_data@%0d", n), 32'(lcd_data), 32'h00);
            else if (n < 44 && (k % 6) < 4)
                chk($sformatf("init_data@%0d", n), 32'(lcd_data), 32'(init_cmds[k / 6]));
        end
    endtask

    task automatic write_char(input logic [7:0] d, input logic rs);
        in_data = d;
        in_rs   = rs;
        in_rw   = 1'b0;
        in_e    = 1'b0;
        tick();
        in_e = 1'b1;
        tick();
        tick();
        in_e = 1'b0;
        tick();
    endtask

    // Remaining five command edges and the return to pass-through.
    task automatic cmd_tail(input logic [7:0] cmd, input string tag);
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk($sformatf("%s_e@%0d", tag, j), 32'(lcd_e), 32'(j == 1 || j == 2));
            chk($sformatf("%s_busy@%0d", tag, j), 32'(busy), 32'(j < 6));
            if (j < 6) chk($sformatf("%s_rs@%0d", tag, j), 32'(lcd_rs), 32'd0);
            if (j < 4) chk($sformatf("%s_data@%0d", tag, j), 32'(lcd_data), 32'(cmd));
        end
    endtask

    initial begin
        // Power-up and init sequence
        tick();
        do_reset();
        run_init(1'b0, 44);
        chk("pass_pos", 32'(char_pos), 32'd0);

        // Single character 0x41 mirrored with one cycle of latency
        in_data = 8'h41; in_rs = 1'b1; in_rw = 1'b0; in_e = 1'b0;
        tick();
        chk("w41_data", 32'(lcd_data), 32'h41);
        chk("w41_rs", 32'(lcd_rs), 32'd1);
        chk("w41_e0", 32'(lcd_e), 32'd0);
        in_e = 1'b1;
        tick();
        chk("w41_e1", 32'(lcd_e), 32'd1);
        chk("w41_pos_mid", 32'(char_pos), 32'd0);
        tick();
        chk("w41_e2", 32'(lcd_e), 32'd1);
        in_e = 1'b0;
        tick();
        chk("w41_efall", 32'(lcd_e), 32'd0);
        chk("w41_pos", 32'(char_pos), 32'd1);
        chk("w41_busy", 32'(busy), 32'd0);

        // Upstream command (rs=0) leaves the cursor index alone
        write_char(8'h0E, 1'b0);
        chk("ucmd_pos", 32'(char_pos), 32'd1);
        chk("ucmd_busy", 32'(busy), 32'd0);

        // Fill line 1: 16th write triggers 0xC0
        for (int i = 0; i < 14; i++) write_char(8'h42 + 8'(i), 1'b1);
        chk("pos15", 32'(char_pos), 32'd15);
        write_char(8'h50, 1'b1);
        chk("l2_busy", 32'(busy), 32'd1);
        chk("l2_data", 32'(lcd_data), 32'hC0);
        chk("l2_rs", 32'(lcd_rs), 32'd0);
        chk("l2_e", 32'(lcd_e), 32'd0);
        chk("l2_pos", 32'(char_pos), 32'd16);
        cmd_tail(8'hC0, "l2");
        chk("l2_pos_after", 32'(char_pos), 32'd16);

        // Fill line 2: 32nd write wraps to 0 and issues 0x80
        for (int i = 0; i < 15; i++) write_char(8'h61 + 8'(i), 1'b1);
        chk("pos31", 32'(char_pos), 32'd31);
        write_char(8'h70, 1'b1);
        chk("l1_busy", 32'(busy), 32'd1);
        chk("l1_data", 32'(lcd_data), 32'h80);
        chk("l1_rs", 32'(lcd_rs), 32'd0);
        chk("l1_pos", 32'(char_pos), 32'd0);
        cmd_tail(8'h80, "l1");

        // 33rd write: plain increment, no command
        write_char(8'h71, 1'b1);
        chk("w33_pos", 32'(char_pos), 32'd1);
        chk("w33_busy", 32'(busy), 32'd0);
        tick();
        chk("w33_busy_after", 32'(busy), 32'd0);
        chk("w33_rs_after", 32'(lcd_rs), 32'd1);
        chk("w33_ovr", 32'(overrun), 32'd0);

        // Input E raised during init: ignored on the pins, overrun sticks
        do_reset();
        run_init(1'b1, 44);
        write_char(8'h33, 1'b1);
        chk("ovr_pass_pos", 32'(char_pos), 32'd1);
        chk("ovr_pass_sticky", 32'(overrun), 32'd1);
        chk("ovr_pass_data", 32'(lcd_data), 32'h33);

        // Reset while lcd_e is high in the 0x01 command, then full restart
        do_reset();
        run_init(1'b0, 33);
        chk("mid_e_high", 32'(lcd_e), 32'd1);
        chk("mid_data", 32'(lcd_data), 32'h01);
        do_reset();
        chk("mid_rst_e", 32'(lcd_e), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        run_init(1'b0, 44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_init_mux.md
Name: lcd_init_mux

Overview:
- Downstream stage between the ASCII character-write stage and the physical HD44780-style 8-bit LCD pins.
- After reset it runs the LCD power-up wait and the init command sequence on its own.
- It then passes the character-write stage's bus (data/E/RW/RS) to the pins and counts written characters.
- It inserts set-DDRAM-address commands to move the cursor to line 2 at the end of line 1, and back to line 1 after line 2.

Parameters:
POWERUP_CYC, 20, idle cycles after reset before the first command (about 19.5 ms at 1024 Hz)
WAIT_CYC, 2, idle cycles after each generated command (covers the 1.52 ms clear)
LINE_LEN, 16, characters per display line

Ports:
clk_1024  in  1  system clock, 1024 Hz
reset  in  1  synchronous, active-high reset
in_data  in  8  character-write stage data bus
in_e  in  1  character-write stage E
in_rw  in  1  character-write stage RW
in_rs  in  1  character-write stage RS
lcd_data  out  8  LCD DB7..DB0
lcd_e  out  1  LCD enable
lcd_rw  out  1  LCD read/write
lcd_rs  out  1  LCD register select
busy  out  1  high whenever the input bus is not being passed through
overrun  out  1  sticky: input E rose while busy
char_pos  out  5  current cursor index, 0..2*LINE_LEN-1

Behaviour:
- Interface: one clock, clk_1024. Reset is synchronous and active-high (port reset), sampled on the rising edge of clk_1024. All outputs are registered.
- Reset values: lcd_data=0x00, lcd_e=0, lcd_rw=0, lcd_rs=0, busy=1, overrun=0, char_pos=0, state=PWRUP, power-up counter=0, command index=0.
- Reset asserted in any state, including while lcd_e=1: outputs take reset values on the next edge and the full sequence restarts with PWRUP.
- PWRUP: hold outputs at reset values for POWERUP_CYC cycles, then go to CMD with command index 0.
- CMD (one command, 4 phases, one cycle each), with lcd_rs=0 and lcd_rw=0 throughout:
  - P0: lcd_data=cmd, lcd_e=0.
  - P1: lcd_e=1.
  - P2: lcd_e=1.
  - P3: lcd_e=0.
  - lcd_data holds cmd through P3. Then go to WAIT.
- WAIT: lcd_e=0 for WAIT_CYC cycles.
  - During init: the command index increments. After the 4th init command, go to PASS.
  - After a cursor command: go to PASS.
- Init commands, in order: 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry mode, increment).
- Total cycles from reset release to the first PASS cycle: POWERUP_CYC + 4*(4+WAIT_CYC) = 44 with defaults.
- busy: 1 in PWRUP, CMD and WAIT; 0 in PASS. It is registered and changes on the same edge as the state change.
- PASS:
  - Each cycle: lcd_data<=in_data, lcd_e<=in_e, lcd_rw<=in_rw, lcd_rs<=in_rs. Latency is one cycle.
  - A character write is detected when lcd_e==1, in_e==0, in_rs==1 and in_rw==0 (falling edge of the input E).
  - On detection, char_pos increments.
  - If the new char_pos equals LINE_LEN: on the same edge enter CMD with cmd=0xC0 (line 2 start) and set busy=1.
  - If the new char_pos equals 2*LINE_LEN: char_pos wraps to 0, and on the same edge enter CMD with cmd=0x80 (line 1 start) and set busy=1.
  - E falling with in_rs==0 (an upstream command) does not change char_pos.
- Overrun:
  - In any non-PASS state, the input bus is ignored. If in_e==1 while the previous sampled input E was 0, set overrun=1.
  - overrun clears only on reset.
  - The previous input E is tracked in a separate register, in_e_d, updated every cycle in all states.
- Simultaneous events: a falling input E on the last PASS cycle before a line-wrap transition is counted normally. Input E activity on the entry edge into CMD is ignored, with overrun rules applied.
- Upstream gates its start with busy.

Test Plan:
1. Release reset, inputs idle -> 20 idle cycles, then commands 0x38, 0x0C, 0x01, 0x06, each with lcd_rs=0 and lcd_e high for exactly 2 cycles. busy falls at cycle 44. overrun=0.
2. In PASS, drive the write sequence for 0x41 (rs=1, E 0-1-1-0) -> lcd_* mirror the inputs one cycle later. char_pos goes 0->1 on the E fall. busy stays 0.
3. Write 16 characters -> after the 16th E fall: busy=1, command 0xC0 issued with lcd_rs=0, busy back to 0 after 6 cycles, char_pos=16.
4. Write 32 characters -> 0x80 issued after the 32nd, char_pos=0. A 33rd write gives char_pos=1 and no command.
5. Raise in_e during init (cycle 25) -> lcd_e and lcd_data follow only the init sequence. overrun=1 and stays 1 through later PASS traffic until reset.
6. Assert reset for 1 cycle while lcd_e=1 in init command 0x01 -> next edge lcd_e=0 and busy=1. The full 44-cycle init repeats from 0x38.
